// File: rtl/multiplier_unit_pkg.sv
// -----------------------------------------------------------------------------
// multiplier_unit_pkg
//   Shared pipeline definitions for the HI/LO multiply unit.
//   - WIDTH_DEFAULT : default operand width (HI and LO are each this wide)
//   - mult_state_e  : sequencing states of the iterative multiplier
// -----------------------------------------------------------------------------
package multiplier_unit_pkg;

   localparam int WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,   // waiting for start_mult
      CALC   = 2'd1,   // one shift-add step per cycle
      FINISH = 2'd2    // sign-correct and publish HI/LO
   } mult_state_e;

endpackage

// File: rtl/multiplier_unit.sv
// -----------------------------------------------------------------------------
// multiplier_unit
//   Iterative radix-2 shift-add multiplier producing the HI/LO pair for
//   MULT (signed) and MULTU (unsigned).
//   Signed operands are multiplied as magnitudes; the product is negated on
//   the final cycle when the operand signs differ.
//
//   Ports
//     clk        in   1      system clock, rising edge
//     reset      in   1      synchronous active-high reset
//     start_mult in   1      single-cycle request to begin a multiply
//     mult_sign  in   1      1 = MULT (signed), 0 = MULTU (unsigned)
//     mult_a     in   WIDTH  rs operand, sampled with start_mult
//     mult_b     in   WIDTH  rt operand, sampled with start_mult
//     hi         out  WIDTH  upper half of the product (MFHI source)
//     lo         out  WIDTH  lower half of the product (MFLO source)
//     mult_busy  out  1      operation in progress (stalls MFHI/MFLO)
//     mult_done  out  1      one-cycle pulse when new HI/LO become visible
// -----------------------------------------------------------------------------
module multiplier_unit
   import multiplier_unit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             mult_sign,
   input  logic [WIDTH-1:0] mult_a,
   input  logic [WIDTH-1:0] mult_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             mult_busy,
   output logic             mult_done
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   mult_state_e        state;
   logic [CNT_W-1:0]   step_cnt;

   logic [2*WIDTH-1:0] acc;       // running partial-product sum
   logic [2*WIDTH-1:0] mcand;     // multiplicand, shifted left each step
   logic [WIDTH-1:0]   mplier;    // multiplier, shifted right each step
   logic               neg;       // final product must be negated

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] acc_next;

   // Magnitudes are unsigned WIDTH-bit values, so -2^(WIDTH-1) negates to
   // itself and reads correctly as +2^(WIDTH-1).
   assign mag_a = (mult_sign && mult_a[WIDTH-1]) ? -mult_a : mult_a;
   assign mag_b = (mult_sign && mult_b[WIDTH-1]) ? -mult_b : mult_b;

   always_comb begin
      // NOTE: default assignment first, so every path drives acc_next and no latch is inferred.
      acc_next = acc;
      if (mplier[0]) begin
         acc_next = acc + mcand;
      end
   end

   assign mult_busy = (state != IDLE);

   // Control and architectural state: cleared by reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state     <= IDLE;
         step_cnt  <= '0;
         hi        <= '0;
         lo        <= '0;
         mult_done <= 1'b0;
      end else begin
         mult_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_mult) begin
                  step_cnt <= '0;
                  state    <= CALC;
               end
            end
            CALC: begin
               step_cnt <= step_cnt + 1'b1;
               if (step_cnt == LAST_STEP) begin
                  state <= FINISH;
               end
            end
            FINISH: begin
               {hi, lo}  <= neg ? -acc : acc;
               mult_done <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath working registers.
   // NOTE: intentionally not reset; they are always loaded on an accepted start before being used.
   always_ff @(posedge clk) begin
      if (state == IDLE && start_mult && !reset) begin
         mcand  <= {{WIDTH{1'b0}}, mag_a};
         mplier <= mag_b;
         neg    <= mult_sign & (mult_a[WIDTH-1] ^ mult_b[WIDTH-1]);
         acc    <= '0;
      end else if (state == CALC) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: tb/tb_multiplier_unit.sv
// -----------------------------------------------------------------------------
// tb_multiplier_unit
//   Self-checking bench: a transaction-level reference model predicts HI/LO,
//   busy and done every cycle from plain 64-bit arithmetic and the documented
//   WIDTH+1 cycle latency; directed cases pin the model to literal results.
// -----------------------------------------------------------------------------
module tb_multiplier_unit;

   localparam int WIDTH = 32;

   logic             clk;
   logic             reset;
   logic             start_mult;
   logic             mult_sign;
   logic [WIDTH-1:0] mult_a;
   logic [WIDTH-1:0] mult_b;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             mult_busy;
   logic             mult_done;

   int checks = 0;
   int errors = 0;

   multiplier_unit #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_mult (start_mult),
      .mult_sign  (mult_sign),
      .mult_a     (mult_a),
      .mult_b     (mult_b),
      .hi         (hi),
      .lo         (lo),
      .mult_busy  (mult_busy),
      .mult_done  (mult_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   function automatic logic [63:0] ref_product(input logic s, input logic [31:0] a,
                                               input logic [31:0] b);
      longint p;
      if (s) p = longint'($signed(a)) * longint'($signed(b));
      else   p = longint'({32'b0, a}) * longint'({32'b0, b});
      return p;
   endfunction

   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [63:0] m_prod = '0;
   int          m_remain = 0;   // edges left until the result is published
   logic        chk_en = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_busy   <= 1'b0;
         m_done   <= 1'b0;
         m_hi     <= '0;
         m_lo     <= '0;
         m_remain <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            m_remain <= m_remain - 1;
            if (m_remain == 1) begin
               m_hi   <= m_prod[63:32];
               m_lo   <= m_prod[31:0];
               m_done <= 1'b1;
               m_busy <= 1'b0;
            end
         end else if (start_mult) begin
            m_busy   <= 1'b1;
            m_remain <= WIDTH + 1;
            m_prod   <= ref_product(mult_sign, mult_a, mult_b);
         end
      end
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_busy", {63'b0, mult_busy}, {63'b0, m_busy});
         check("cyc_done", {63'b0, mult_done}, {63'b0, m_done});
         check("cyc_hi", {32'b0, hi}, {32'b0, m_hi});
         check("cyc_lo", {32'b0, lo}, {32'b0, m_lo});
      end
   end

   // ---------------------------------------------------------------- helpers
   // Leaves the caller at the negedge following the sampling edge (edge 0).
   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start_mult = 1'b1;
      mult_sign  = s;
      mult_a     = a;
      mult_b     = b;
      @(negedge clk);
      start_mult = 1'b0;
   endtask

   // Returns the number of edges until mult_done is seen, or -1 on timeout.
   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (mult_done) begin
            cyc = i;
            break;
         end
      end
      if (cyc < 0) check("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic run_op(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e_hi,
                         input logic [31:0] e_lo);
      int cyc;
      issue(s, a, b);
      wait_done(cyc);
      check({name, "_latency"}, 64'(cyc), 64'd33);
      check({name, "_hi"}, {32'b0, hi}, {32'b0, e_hi});
      check({name, "_lo"}, {32'b0, lo}, {32'b0, e_lo});
      @(negedge clk);
      check({name, "_done_one_cycle"}, {63'b0, mult_done}, 64'd0);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int cyc;
      int pulses;
      logic [31:0] pool [6];

      reset      = 1'b1;
      start_mult = 1'b0;
      mult_sign  = 1'b0;
      mult_a     = '0;
      mult_b     = '0;

      // Reset state; reset also wins over a simultaneous start.
      repeat (2) @(negedge clk);
      start_mult = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      check("reset_busy", {63'b0, mult_busy}, 64'd0);
      check("reset_done", {63'b0, mult_done}, 64'd0);
      check("reset_hi", {32'b0, hi}, 64'd0);
      check("reset_lo", {32'b0, lo}, 64'd0);
      start_mult = 1'b0;
      reset      = 1'b0;

      // Literal results.
      run_op("multu_7x6", 1'b0, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A);
      run_op("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult_minint", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      run_op("mult_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);

      // Start while busy is ignored: 7x6 then 9x9 sampled at edge 10.
      issue(1'b0, 32'd7, 32'd6);
      repeat (9) @(negedge clk);
      start_mult = 1'b1;
      mult_a     = 32'd9;
      mult_b     = 32'd9;
      @(negedge clk);
      start_mult = 1'b0;
      check("ignore_hold_lo", {32'b0, lo}, 64'h1);
      wait_done(cyc);
      check("ignore_latency", 64'(cyc), 64'd23);
      check("ignore_lo", {32'b0, lo}, 64'h2A);

      // Back-to-back: new start in the done cycle.
      issue(1'b0, 32'd3, 32'd4);
      wait_done(cyc);
      start_mult = 1'b1;
      mult_a     = 32'd5;
      mult_b     = 32'd5;
      @(negedge clk);
      start_mult = 1'b0;
      check("b2b_busy", {63'b0, mult_busy}, 64'd1);
      check("b2b_hold_lo", {32'b0, lo}, 64'd12);
      wait_done(cyc);
      check("b2b_latency", 64'(cyc), 64'd33);
      check("b2b_lo", {32'b0, lo}, 64'd25);

      // Reset in the middle of CALC (edge 15 of the operation).
      issue(1'b0, 32'd7, 32'd6);
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_hi", {32'b0, hi}, 64'd0);
      check("midreset_lo", {32'b0, lo}, 64'd0);
      check("midreset_busy", {63'b0, mult_busy}, 64'd0);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (mult_done) pulses++;
      end
      check("midreset_no_done", 64'(pulses), 64'd0);

      // Randomized traffic: sporadic starts (many while busy), corner-biased
      // operands, occasional resets.
      pool[0] = 32'h0000_0000;
      pool[1] = 32'h0000_0001;
      pool[2] = 32'hFFFF_FFFF;
      pool[3] = 32'h8000_0000;
      pool[4] = 32'h7FFF_FFFF;
      pool[5] = 32'h0000_FFFF;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         reset      = ($urandom_range(0, 599) == 0);
         start_mult = ($urandom_range(0, 5) == 0);
         mult_sign  = 1'($urandom_range(0, 1));
         mult_a     = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
         mult_b     = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      end
      @(negedge clk);
      reset      = 1'b0;
      start_mult = 1'b0;
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
